// File: rtl/pc_sequencer.sv
// Next-PC controller for the IF stage: owns the PC, issues valid/ready fetches, redirects and flushes IF/ID.
// All outputs registered; redirect target appears one cycle after the request, fetch resumes one cycle later.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'd100,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    input  logic        exception_i,
    input  logic        halt_i,
    input  logic        imem_ready_i,
    output logic [31:0] pc_o,
    output logic        pc_valid_o,
    output logic        if_flush_o,
    output logic        misalign_o,
    output logic [31:0] fetch_count_o
);

    typedef enum logic [1:0] {BOOT, FETCH, REDIRECT, HALTED} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pc_valid_q, pc_valid_d;
    logic        if_flush_q, if_flush_d;
    logic        misalign_q, misalign_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic        accept;
    logic        redirect_req;
    logic [31:0] req_tgt;
    logic        req_mis;

    assign accept       = pc_valid_q & imem_ready_i;
    assign redirect_req = exception_i | jump_i | branch_taken_i;
    assign req_tgt      = jump_i ? jump_target_i : branch_target_i;
    // Exception always goes to the vector, so only jump/branch targets can be misaligned.
    assign req_mis      = ~exception_i & (jump_i | branch_taken_i) & (req_tgt[1:0] != 2'b00);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pc_valid_d    = pc_valid_q;
        if_flush_d    = 1'b0;
        misalign_d    = 1'b0;
        fetch_count_d = fetch_count_q;
        case (state_q)
            BOOT: begin
                if (halt_i) begin
                    state_d    = HALTED;
                    pc_valid_d = 1'b0;
                end else begin
                    state_d    = FETCH;
                    pc_valid_d = 1'b1;
                end
            end
            FETCH, REDIRECT: begin
                if (halt_i) begin
                    state_d    = HALTED;
                    pc_valid_d = 1'b0;
                    if (accept) fetch_count_d = fetch_count_q + 32'd1;
                end else if (redirect_req) begin
                    // Outstanding fetch is abandoned: not counted.
                    state_d    = REDIRECT;
                    pc_valid_d = 1'b0;
                    if_flush_d = 1'b1;
                    misalign_d = req_mis;
                    pc_d       = (exception_i | req_mis) ? EXC_VECTOR : req_tgt;
                end else if (state_q == REDIRECT) begin
                    state_d    = FETCH;
                    pc_valid_d = 1'b1;
                end else begin
                    if (accept) fetch_count_d = fetch_count_q + 32'd1;
                    if (accept && !stall_i) pc_d = pc_q + 32'd4;
                end
            end
            HALTED: begin
                pc_valid_d = 1'b0;
            end
            default: begin
                state_d    = BOOT;
                pc_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            pc_valid_q    <= 1'b0;
            if_flush_q    <= 1'b0;
            misalign_q    <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pc_valid_q    <= pc_valid_d;
            if_flush_q    <= if_flush_d;
            misalign_q    <= misalign_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign pc_o          = pc_q;
    assign pc_valid_o    = pc_valid_q;
    assign if_flush_o    = if_flush_q;
    assign misalign_o    = misalign_q;
    assign fetch_count_o = fetch_count_q;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC controller for the IF stage of the MIPS pipeline. It owns the program counter register and decides each cycle whether the PC advances, holds, or is redirected. Redirect sources are exception, jump and taken branch; holds come from hazard stalls and instruction-memory backpressure. It presents a valid/ready fetch request to instruction memory and flushes the IF/ID register on every redirect.

## Interface
- RESET_PC, 32'd100, PC loaded on reset
- EXC_VECTOR, 32'h0000_0180, exception/misalignment target
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hazard-unit stall; hold PC
- branch_taken  in  1  branch resolved taken (EX stage)
- branch_target  in  32  branch destination
- jump  in  1  jump request
- jump_target  in  32  jump destination
- exception  in  1  exception request
- halt  in  1  enter HALTED (sticky until reset)
- imem_ready  in  1  instruction memory accepts current pc
- pc  out  32  current fetch address (registered)
- pc_valid  out  1  fetch request valid (registered)
- if_flush  out  1  one-cycle flush of IF/ID (registered)
- misalign  out  1  one-cycle pulse: redirect target had [1:0]!=0
- fetch_count  out  32  number of accepted fetches

## Operation
- States: BOOT, FETCH, REDIRECT, HALTED.
- Reset (any state, any cycle, overrides all inputs): pc=RESET_PC, pc_valid=0, if_flush=0, misalign=0, fetch_count=0, state=BOOT.
- BOOT: ignores all requests except halt; next edge -> FETCH (or HALTED if halt=1).
- Fetch accepted when pc_valid & imem_ready; fetch_count increments by 1 (modulo 2^32) on that edge only.
- Priority (FETCH and REDIRECT): halt > exception > jump > branch_taken > stall > imem backpressure > sequential.
- Redirect (exception/jump/branch_taken): pc <= target (EXC_VECTOR for exception), if_flush=1 and pc_valid=0 for the following cycle, state -> REDIRECT. The redirect proceeds regardless of stall or imem_ready, and any outstanding fetch is abandoned without being counted.
- Misaligned jump/branch target ([1:0]!=0): pc <= EXC_VECTOR, misalign=1 for one cycle, otherwise treated as a redirect.
- REDIRECT lasts one cycle (bubble), then -> FETCH with pc_valid=1. A new redirect arriving in REDIRECT reloads pc and stays in REDIRECT for one more cycle.
- FETCH with stall=1 or imem_ready=0: pc held, pc_valid stays 1.
- FETCH accepted with no stall: pc <= pc+4, 32-bit wrap (32'hFFFF_FFFC -> 0).
- Accept and stall in the same cycle: the fetch counts, pc holds (stall wins for the PC).
- halt: -> HALTED at the next edge; pc held; pc_valid=0, if_flush=0. HALTED is left only via reset.

## Timing
- All outputs registered and change only on rising edges of clock.
- Reset release: first edge BOOT->FETCH, pc_valid=1 with pc=RESET_PC from the following cycle.
- Sequential throughput: one PC per cycle while imem_ready=1 and stall=0.
- Redirect latency: request sampled at edge N. pc=target and if_flush=1 in cycle N+1; pc_valid=1 at target in cycle N+2.
- if_flush and misalign are single-cycle pulses, never held.

## Test plan
- Reset then 4 cycles with imem_ready=1 -> pc sequence 100,100(valid),104,108,112; fetch_count=3.
- stall=1 for 3 cycles at pc=108 -> pc stays 108, pc_valid=1, fetch_count advances per accepted cycle, no flush.
- branch_taken=1, branch_target=0x200, with stall=1 and jump=1, jump_target=0x400 in the same cycle -> pc=0x400, if_flush pulse, bubble, then fetch 0x400, 0x404.
- jump_target=0x202 -> pc=0x180, misalign=1 for one cycle, if_flush=1.
- pc=0xFFFFFFFC accepted -> next pc=0x00000000; exception during REDIRECT -> pc=0x180, bubble extended by one cycle.
- halt=1 mid-stream -> HALTED, pc_valid=0, later branch ignored; reset mid-REDIRECT -> pc=100, state BOOT, fetch_count=0.
